reg_port_master: RTL
====================

Name: reg_port_master

Overview:
- Initiator for a single-register write/read port: the register side takes a write-data bus, a one-bit choice and returns a read-data bus.
- Accepts write/read commands from upstream on a valid/ready handshake and sequences choice and write data.
- Captures the register's registered read data and returns one response per command on a second valid/ready handshake.
- Sits between a CPU/testbench-style command source and a 16-bit register instance, sharing its clock and reset.

Parameters:
- WIDTH, 16, data width of command, register and response buses.
- CNT_W, 16, width of the transaction counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  master can accept a command.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_wdata  input  WIDTH  write data, sampled on accept.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  downstream takes the response.
- rsp_rdata  output  WIDTH  read data; 0 for write responses.
- rsp_error  output  1  write-verify mismatch; 0 unless the optional feature is enabled.
- reg_wdata  output  WIDTH  drives the register's write port.
- reg_choice  output  1  drives the register's choice: 0 = write, 1 = read.
- reg_rdata  input  WIDTH  the register's read port, updated on the clock edge at which choice is 1.
- txn_count  output  CNT_W  completed-response counter.

Behaviour:
Reset and handshakes:
- Reset: while reset = 0, asynchronously force the following:
  - state IDLE, cmd_ready 0, rsp_valid 0.
  - rsp_rdata 0, rsp_error 0.
  - reg_choice 1, reg_wdata 0, txn_count 0.
- cmd_ready is registered. It is 1 only in IDLE, and rises at the first rising edge after reset is released.
- Command accept = cmd_valid && cmd_ready at a rising edge. At accept, latch cmd_write and cmd_wdata.

State machine:
- States: IDLE, WRITE, RD_ISSUE, RD_CAPTURE, RESP.
- IDLE: reg_choice = 1 (harmless read). Accept moves to WRITE or RD_ISSUE and drops cmd_ready.
- WRITE, one cycle: reg_choice = 0 and reg_wdata = latched data. The register stores the data at the end of this cycle. Next state is RESP with rsp_rdata = 0.
- RD_ISSUE, one cycle: reg_choice = 1. The register drives reg_rdata at the end of this cycle.
- RD_CAPTURE, one cycle: reg_choice = 1. Sample reg_rdata into rsp_rdata at the end of the cycle, then go to RESP.
- RESP: rsp_valid = 1, and rsp_rdata/rsp_error are held stable while rsp_ready = 0.
  - On rsp_valid && rsp_ready: clear rsp_valid, increment txn_count, return to IDLE, set cmd_ready.

Latency:
- Write: rsp_valid is high 2 edges after the accept edge.
- Read: rsp_valid is high 3 edges after the accept edge.
- Minimum command-to-command spacing:
  - Write: 3 cycles.
  - Read: 4 cycles.

Boundary conditions:
- Only one command is outstanding at a time. cmd_valid is ignored outside IDLE, and commands are never dropped once accepted.
- reg_rdata is undefined while choice is 0. The master never samples it in WRITE.
- reg_wdata holds its last written value outside WRITE. It only matters when reg_choice = 0.
- txn_count wraps from all-ones to 0 with no flag.
- Reset mid-operation: an in-flight command is abandoned with no response and no count increment.
  - If reset hits during WRITE, the register content is defined by the register's own reset (the same reset net), which clears it to 0.
- cmd_valid held high across reset release: it is accepted no earlier than the second rising edge after release, once cmd_ready is 1.

Optional Feature:
- Macro: REG_PORT_MASTER_WRITE_VERIFY_EN.
- Defined:
  - WRITE goes to RD_ISSUE → RD_CAPTURE instead of RESP.
  - In RD_CAPTURE, compare reg_rdata with the latched write data. rsp_error = 1 on mismatch.
  - rsp_rdata carries the read-back value.
  - Write latency becomes 4 edges after accept.
- Undefined: rsp_error is tied 0 and the write path is as above.

Test Plan:
- After reset release: issue read → rsp_valid 3 edges after accept, rsp_rdata = 0x0000, txn_count = 1.
- Write 0xA5A5, then read → write response rsp_rdata = 0x0000; read response rsp_rdata = 0xA5A5; reg_choice is 0 for exactly one cycle; txn_count = 2.
- Read with rsp_ready held low 4 cycles after rsp_valid → rsp_valid and rsp_rdata stay stable, cmd_ready stays 0, a cmd_valid pulse is not accepted; response completes on the cycle rsp_ready rises.
- Assert reset in RD_CAPTURE → all outputs at reset values immediately; no response emitted; next read returns 0x0000.
- Preload txn_count with 0xFFFE via 0xFFFE completed transactions (or force in bench), then 2 more → txn_count = 0x0000.
- With REG_PORT_MASTER_WRITE_VERIFY_EN and a register model whose bit 3 is stuck at 0: write 0x00FF → rsp_error = 1, rsp_rdata = 0x00F7; write 0x00F0 → rsp_error = 0.

Source files
------------

// File: rtl/reg_port_master.sv
// ---------------------------------------------------------------------------
// reg_port_master
//
// Purpose:
//   Initiator for a single-register write/read port. Upstream commands
//   arrive on a valid/ready handshake. Each command is turned into a
//   one-cycle write (reg_choice = 0) or a two-cycle read sequence
//   (issue + capture). One response per command is returned on a second
//   valid/ready handshake. Only one command is in flight at a time.
//
// Optional feature (compile-time macro):
//   REG_PORT_MASTER_WRITE_VERIFY_EN
//     Defined   : every write is followed by a read-back. rsp_rdata carries
//                 the read-back value. rsp_error flags a mismatch against
//                 the written data.
//     Undefined : write responses carry rsp_rdata = 0 and rsp_error = 0.
//
// Parameters:
//   WIDTH  - data width of the command, register and response buses
//   CNT_W  - width of the completed-transaction counter
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   reset      in   asynchronous, active-low reset
//   cmd_valid  in   command present
//   cmd_ready  out  master can accept a command (registered, IDLE only)
//   cmd_write  in   1 = write, 0 = read
//   cmd_wdata  in   write data, sampled on accept
//   rsp_valid  out  response present
//   rsp_ready  in   downstream takes the response
//   rsp_rdata  out  read data (0 for write responses unless verifying)
//   rsp_error  out  write-verify mismatch flag
//   reg_wdata  out  register write port
//   reg_choice out  register choice: 0 = write, 1 = read
//   reg_rdata  in   register read port, updated on edges where choice = 1
//   txn_count  out  completed-response counter, wraps silently
// ---------------------------------------------------------------------------
module reg_port_master #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [WIDTH-1:0] cmd_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_error,
    output logic [WIDTH-1:0] reg_wdata,
    output logic             reg_choice,
    input  logic [WIDTH-1:0] reg_rdata,
    output logic [CNT_W-1:0] txn_count
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ISSUE,
        RD_CAPTURE,
        RESP
    } state_t;

    state_t state;

`ifdef REG_PORT_MASTER_WRITE_VERIFY_EN
    // Distinguishes a verifying write from a plain read once both share
    // the RD_ISSUE/RD_CAPTURE path.
    logic is_write;
`endif

    // All outputs are registered. reg_choice is loaded with the value the
    // *next* state needs, so it is already correct during that state's cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cmd_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_error  <= 1'b0;
            reg_choice <= 1'b1;
            reg_wdata  <= '0;
            txn_count  <= '0;
`ifdef REG_PORT_MASTER_WRITE_VERIFY_EN
            is_write   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    reg_choice <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
`ifdef REG_PORT_MASTER_WRITE_VERIFY_EN
                        is_write  <= cmd_write;
`endif
                        if (cmd_write) begin
                            // reg_wdata doubles as the latched write data;
                            // it is left unchanged by reads.
                            reg_wdata  <= cmd_wdata;
                            reg_choice <= 1'b0;
                            state      <= WRITE;
                        end else begin
                            state <= RD_ISSUE;
                        end
                    end else begin
                        // First edge after reset release raises cmd_ready,
                        // so acceptance can only happen from the second edge.
                        cmd_ready <= 1'b1;
                    end
                end

                WRITE: begin
                    // The register stores reg_wdata at the end of this cycle.
                    reg_choice <= 1'b1;
`ifdef REG_PORT_MASTER_WRITE_VERIFY_EN
                    state <= RD_ISSUE;
`else
                    rsp_rdata <= '0;
                    rsp_error <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
`endif
                end

                RD_ISSUE: begin
                    // The register drives reg_rdata at the end of this cycle.
                    reg_choice <= 1'b1;
                    state      <= RD_CAPTURE;
                end

                RD_CAPTURE: begin
                    reg_choice <= 1'b1;
                    rsp_rdata  <= reg_rdata;
`ifdef REG_PORT_MASTER_WRITE_VERIFY_EN
                    rsp_error  <= is_write && (reg_rdata != reg_wdata);
`else
                    rsp_error  <= 1'b0;
`endif
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end

                RESP: begin
                    // rsp_rdata/rsp_error are untouched here, so they stay
                    // stable for as long as rsp_ready is held low.
                    reg_choice <= 1'b1;
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        txn_count <= txn_count + 1'b1;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state      <= IDLE;
                    reg_choice <= 1'b1;
                    rsp_valid  <= 1'b0;
                    cmd_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule
